// File: rtl/img_stream_pkg.sv
// ---------------------------------------------------------------------------
// img_stream_pkg
// Shared constants and types for the image streamer.
//   NPIX   : default pixels per frame (28x28)
//   PIX_W  : default normalized pixel width
//   ADDR_W : pixel index width, fixed so oADDR is always 10 bits
//   state_e: streamer FSM states
// ---------------------------------------------------------------------------
package img_stream_pkg;

    localparam int NPIX   = 784;
    localparam int PIX_W  = 16;
    localparam int ADDR_W = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage : img_stream_pkg

// File: rtl/img_bank.sv
// ---------------------------------------------------------------------------
// img_bank
// One full frame capture register with load enable, synchronous clear and an
// index-selected read port.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset, clears the frame
//   i_clr   : synchronous clear (dominates i_load)
//   i_load  : capture i_data into the frame register
//   i_data  : packed frame, element 0 in the low PIX_W bits
//   i_raddr : pixel index to read; indices >= NPIX read as 0
//   o_word  : pixel at i_raddr
//   o_img   : whole stored frame (source for bank-to-bank copies)
// ---------------------------------------------------------------------------
module img_bank
    import img_stream_pkg::ADDR_W;
#(
    parameter int NPIX  = 784,
    parameter int PIX_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [NPIX*PIX_W-1:0] i_data,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [PIX_W-1:0]      o_word,
    output logic [NPIX*PIX_W-1:0] o_img
);

    logic [NPIX*PIX_W-1:0] r_img;

    // NOTE: the frame store is reset like any other register because the
    // design must come out of reset with both banks holding zeros; it is
    // plain flops, not a RAM macro, so this costs nothing structurally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_img <= '0;
        end else if (i_clr) begin
            r_img <= '0;
        end else if (i_load) begin
            r_img <= i_data;
        end
    end

    // Compare-based mux instead of a direct index so an out-of-range index
    // reads 0 and the select width need not match log2(NPIX).
    // NOTE: o_word gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_word = '0;
        for (int k = 0; k < NPIX; k++) begin
            if (i_raddr == ADDR_W'(k)) begin
                o_word = r_img[k*PIX_W +: PIX_W];
            end
        end
    end

    assign o_img = r_img;

endmodule : img_bank

// File: rtl/img_streamer.sv
// ---------------------------------------------------------------------------
// img_streamer
// Streams normalized frames pixel by pixel to the NN input stage over a
// valid/ready handshake. An ACTIVE bank holds the frame being streamed and a
// PENDING bank holds at most one waiting frame; a frame arriving while both
// are occupied is dropped and flagged.
//   iCLK       : clock, rising edge
//   iRST       : asynchronous active-high reset
//   iSTART     : one-cycle pulse, iIMG holds a complete frame
//   iIMG       : packed frame, element 0 = top-left, row-major
//   iABORT     : synchronous flush back to IDLE, drops any pending frame
//   oVALID     : oDATA/oADDR/oLAST valid
//   iREADY     : consumer accepts the word when oVALID & iREADY
//   oDATA      : current pixel
//   oADDR      : index of current pixel
//   oLAST      : current pixel is the last of the frame
//   oBUSY      : streaming or a pending frame is held
//   oOVF       : sticky, a frame was dropped
//   oFRAME_CNT : frames fully streamed, modulo 256
// ---------------------------------------------------------------------------
module img_streamer #(
    parameter int NPIX  = img_stream_pkg::NPIX,
    parameter int PIX_W = img_stream_pkg::PIX_W
) (
    input  logic                              iCLK,
    input  logic                              iRST,
    input  logic                              iSTART,
    input  logic [NPIX*PIX_W-1:0]             iIMG,
    input  logic                              iABORT,
    output logic                              oVALID,
    input  logic                              iREADY,
    output logic [PIX_W-1:0]                  oDATA,
    output logic [img_stream_pkg::ADDR_W-1:0] oADDR,
    output logic                              oLAST,
    output logic                              oBUSY,
    output logic                              oOVF,
    output logic [7:0]                        oFRAME_CNT
);

    import img_stream_pkg::ADDR_W;
    import img_stream_pkg::state_e;
    import img_stream_pkg::IDLE;
    import img_stream_pkg::STREAM;

    state_e              r_state;
    logic                r_valid;
    logic [PIX_W-1:0]    r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_last;
    logic                r_busy;
    logic                r_ovf;
    logic [7:0]          r_frame_cnt;
    logic                r_pend_full;

    logic                  w_hs;
    logic                  w_final;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic                  w_ld_act;
    logic                  w_act_from_pend;
    logic                  w_ld_pend;
    logic                  w_next_full;
    logic                  w_next_stream;
    logic                  w_set_ovf;
    logic [NPIX*PIX_W-1:0] w_act_src;
    logic [PIX_W-1:0]      w_first_word;
    logic [PIX_W-1:0]      w_act_word;
    logic [NPIX*PIX_W-1:0] w_act_img;
    logic [PIX_W-1:0]      w_pend_word0;
    logic [NPIX*PIX_W-1:0] w_pend_img;

    assign w_hs       = r_valid & iREADY;
    assign w_final    = w_hs & r_last;
    assign w_addr_nxt = r_addr + ADDR_W'(1);

    // Bank control and next-state decisions. A frame finishing and a new
    // iSTART in the same cycle are resolved together so the released bank
    // can take the incoming frame.
    always_comb begin
        w_ld_act        = 1'b0;
        w_act_from_pend = 1'b0;
        w_ld_pend       = 1'b0;
        w_next_full     = r_pend_full;
        w_next_stream   = (r_state == STREAM);
        w_set_ovf       = 1'b0;
        if (iABORT) begin
            w_next_full   = 1'b0;
            w_next_stream = 1'b0;
        end else if (r_state == IDLE) begin
            if (iSTART) begin
                w_ld_act      = 1'b1;
                w_next_stream = 1'b1;
            end
        end else if (w_final) begin
            if (r_pend_full) begin
                w_ld_act        = 1'b1;
                w_act_from_pend = 1'b1;
                if (iSTART) begin
                    w_ld_pend = 1'b1;
                end else begin
                    w_next_full = 1'b0;
                end
            end else if (iSTART) begin
                w_ld_act = 1'b1;
            end else begin
                w_next_stream = 1'b0;
            end
        end else if (iSTART) begin
            if (!r_pend_full) begin
                w_ld_pend   = 1'b1;
                w_next_full = 1'b1;
            end else begin
                w_set_ovf = 1'b1;
            end
        end
    end

    // Swap is a copy: PENDING contents are loaded into ACTIVE, and word 0 of
    // whichever frame becomes active is presented the very next cycle.
    assign w_act_src    = w_act_from_pend ? w_pend_img : iIMG;
    assign w_first_word = w_act_from_pend ? w_pend_word0 : iIMG[PIX_W-1:0];

    img_bank #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W)
    ) u_active (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_clr   (iABORT),
        .i_load  (w_ld_act),
        .i_data  (w_act_src),
        .i_raddr (w_addr_nxt),
        .o_word  (w_act_word),
        .o_img   (w_act_img)
    );

    img_bank #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W)
    ) u_pending (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_clr   (iABORT),
        .i_load  (w_ld_pend),
        .i_data  (iIMG),
        .i_raddr ('0),
        .o_word  (w_pend_word0),
        .o_img   (w_pend_img)
    );

    // FSM and all registered outputs.
    // NOTE: every register here uses <= so all updates see the pre-edge
    // values; mixing in = would make results depend on statement order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_state     <= w_next_stream ? STREAM : IDLE;
            r_pend_full <= w_next_full;
            r_busy      <= w_next_stream | w_next_full;
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_final && !iABORT) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (iABORT) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_addr  <= '0;
                r_last  <= 1'b0;
            end else if (w_ld_act) begin
                r_valid <= 1'b1;
                r_data  <= w_first_word;
                r_addr  <= '0;
                r_last  <= (NPIX == 1);
            end else if (w_final) begin
                r_valid <= 1'b0;
                r_addr  <= '0;
                r_last  <= 1'b0;
            end else if (w_hs) begin
                r_data <= w_act_word;
                r_addr <= w_addr_nxt;
                r_last <= (w_addr_nxt == ADDR_W'(NPIX - 1));
            end
        end
    end

    assign oVALID     = r_valid;
    assign oDATA      = r_data;
    assign oADDR      = r_addr;
    assign oLAST      = r_last;
    assign oBUSY      = r_busy;
    assign oOVF       = r_ovf;
    assign oFRAME_CNT = r_frame_cnt;

endmodule : img_streamer

// File: tb/tb_img_streamer.sv
// ---------------------------------------------------------------------------
// tb_img_streamer
// Self-checking bench for img_streamer. A reduced frame size keeps the
// 256-frame counter wrap short. The reference model treats the streamer as a
// queue of at most two frames: each accepted word advances a read index,
// a finished frame is popped before a same-cycle start is considered, and a
// start that finds the queue full is dropped.
// ---------------------------------------------------------------------------
module tb_img_streamer;

    localparam int NPIX  = 32;
    localparam int PIX_W = 16;
    localparam int IMG_W = NPIX * PIX_W;

    logic             iCLK = 1'b0;
    logic             iRST;
    logic             iSTART;
    logic [IMG_W-1:0] iIMG;
    logic             iABORT;
    logic             oVALID;
    logic             iREADY;
    logic [PIX_W-1:0] oDATA;
    logic [9:0]       oADDR;
    logic             oLAST;
    logic             oBUSY;
    logic             oOVF;
    logic [7:0]       oFRAME_CNT;

    img_streamer #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iIMG       (iIMG),
        .iABORT     (iABORT),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oDATA      (oDATA),
        .oADDR      (oADDR),
        .oLAST      (oLAST),
        .oBUSY      (oBUSY),
        .oOVF       (oOVF),
        .oFRAME_CNT (oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [IMG_W-1:0] m_q[$];
    int               m_idx = 0;
    int               m_cnt = 0;
    bit               m_ovf = 1'b0;

    function automatic logic [PIX_W-1:0] word_of(input logic [IMG_W-1:0] f, input int k);
        return f[k*PIX_W +: PIX_W];
    endfunction

    function automatic logic [IMG_W-1:0] ramp_frame(input int base);
        logic [IMG_W-1:0] f;
        for (int k = 0; k < NPIX; k++) f[k*PIX_W +: PIX_W] = PIX_W'(base + k);
        return f;
    endfunction

    function automatic logic [IMG_W-1:0] rand_frame();
        logic [IMG_W-1:0] f;
        for (int k = 0; k < NPIX; k++) f[k*PIX_W +: PIX_W] = PIX_W'($urandom);
        return f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit start, input bit abort, input bit ready,
                              input logic [IMG_W-1:0] img);
        if (abort) begin
            m_q.delete();
            m_idx = 0;
            return;
        end
        if (m_q.size() > 0 && ready) begin
            m_idx++;
            if (m_idx == NPIX) begin
                void'(m_q.pop_front());
                m_idx = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        if (start) begin
            if (m_q.size() < 2) m_q.push_back(img);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        bit v;
        v = (m_q.size() > 0);
        check("valid", oVALID, v);
        check("busy", oBUSY, v);
        check("frame_cnt", oFRAME_CNT, m_cnt);
        check("ovf", oOVF, m_ovf);
        if (v) begin
            check("addr", oADDR, m_idx);
            check("data", oDATA, word_of(m_q[0], m_idx));
            check("last", oLAST, (m_idx == NPIX - 1));
        end else begin
            check("last_idle", oLAST, 0);
        end
    endtask

    task automatic tick(input bit start, input bit abort, input bit ready,
                        input logic [IMG_W-1:0] img);
        @(negedge iCLK);
        iSTART = start;
        iABORT = abort;
        iREADY = ready;
        iIMG   = img;
        @(posedge iCLK);
        model_edge(start, abort, ready, img);
        #1;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"}, oVALID, 0);
        check({pfx, "_data"}, oDATA, 0);
        check({pfx, "_addr"}, oADDR, 0);
        check({pfx, "_last"}, oLAST, 0);
        check({pfx, "_busy"}, oBUSY, 0);
        check({pfx, "_ovf"}, oOVF, 0);
        check({pfx, "_cnt"}, oFRAME_CNT, 0);
    endtask

    task automatic async_reset();
        @(negedge iCLK);
        iSTART = 1'b0;
        iABORT = 1'b0;
        #2 iRST = 1'b1;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [IMG_W-1:0] fa, fb, fc;
        int cnt0, vcount, sent;
        bit sb, sc, s;

        iRST = 1'b1; iSTART = 1'b0; iABORT = 1'b0; iREADY = 1'b0; iIMG = '0;
        repeat (2) @(posedge iCLK);
        #1;
        check_all_zero("rst");
        @(negedge iCLK);
        iRST = 1'b0;

        // Ramp frame, consumer always ready.
        fa = ramp_frame(0);
        tick(1, 0, 1, fa);
        check("ramp_first_addr", oADDR, 0);
        check("ramp_first_data", oDATA, 0);
        for (int i = 0; i < NPIX + 3; i++) tick(0, 0, 1, '0);
        check("ramp_cnt", oFRAME_CNT, 1);
        check("ramp_busy", oBUSY, 0);

        // Ready toggling: first valid cycle sees ready=0.
        vcount = 0;
        tick(1, 0, 0, rand_frame());
        vcount += int'(oVALID);
        for (int i = 0; i < 2 * NPIX + 4; i++) begin
            tick(0, 0, i[0], '0);
            vcount += int'(oVALID);
        end
        check("toggle_valid_cycles", vcount, 2 * NPIX);

        // A streaming, B at quarter, C at half: B follows, C dropped.
        cnt0 = m_cnt; fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        sb = 0; sc = 0;
        tick(1, 0, 1, fa);
        for (int i = 0; i < 3 * NPIX; i++) begin
            s = 0;
            if (!sb && m_idx == NPIX / 4) begin s = 1; sb = 1; tick(1, 0, 1, fb); end
            else if (!sc && m_idx == NPIX / 2) begin s = 1; sc = 1; tick(1, 0, 1, fc); end
            if (!s) tick(0, 0, 1, '0);
        end
        check("ovf_drop", oOVF, 1);
        check("ovf_cnt", oFRAME_CNT, (cnt0 + 2) % 256);

        // Start coinciding with final handshake, pending empty.
        cnt0 = m_cnt; fa = rand_frame(); fb = rand_frame(); sb = 0;
        tick(1, 0, 1, fa);
        for (int i = 0; i < 2 * NPIX + 4; i++) begin
            s = (!sb && m_q.size() > 0 && m_idx == NPIX - 1);
            tick(s, 0, 1, s ? fb : '0);
            if (s) begin
                sb = 1;
                check("restart_addr", oADDR, 0);
                check("restart_data", oDATA, fb[PIX_W-1:0]);
            end
        end
        check("restart_cnt", oFRAME_CNT, (cnt0 + 2) % 256);

        // Start coinciding with final handshake, pending full: C accepted.
        cnt0 = m_cnt; fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        sb = 0; sc = 0;
        tick(1, 0, 1, fa);
        for (int i = 0; i < 4 * NPIX; i++) begin
            s = 0;
            if (!sb && m_idx == NPIX / 2) begin s = 1; sb = 1; tick(1, 0, 1, fb); end
            else if (sb && !sc && m_idx == NPIX - 1) begin s = 1; sc = 1; tick(1, 0, 1, fc); end
            if (!s) tick(0, 0, 1, '0);
        end
        check("swap_start_cnt", oFRAME_CNT, (cnt0 + 3) % 256);

        // Abort with pending full, coinciding with a start.
        cnt0 = m_cnt; sb = 0; sc = 0;
        tick(1, 0, 1, rand_frame());
        for (int i = 0; i < NPIX; i++) begin
            if (sc) tick(0, 0, 1, '0);
            else if (!sb && m_idx == NPIX / 4) begin sb = 1; tick(1, 0, 1, rand_frame()); end
            else if (sb && m_idx == (3 * NPIX) / 8) begin
                sc = 1;
                tick(1, 1, 1, rand_frame());
                check("abort_valid", oVALID, 0);
                check("abort_busy", oBUSY, 0);
                check("abort_cnt", oFRAME_CNT, cnt0);
            end else tick(0, 0, 1, '0);
        end
        fa = ramp_frame(100);
        tick(1, 0, 1, fa);
        check("post_abort_addr", oADDR, 0);
        check("post_abort_data", oDATA, 100);
        for (int i = 0; i < NPIX + 3; i++) tick(0, 0, 1, '0);
        check("post_abort_cnt", oFRAME_CNT, (cnt0 + 1) % 256);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0, rand_frame());
        for (int i = 0; i < 2 * NPIX + 4; i++) tick(0, 0, 1, '0);

        // Reset mid-stream, then 256 back-to-back frames wrap the counter.
        tick(1, 0, 1, rand_frame());
        for (int i = 0; i < NPIX / 2; i++) tick(0, 0, 1, '0);
        async_reset();
        sent = 0;
        for (int i = 0; i < 256 * NPIX + 2 * NPIX + 8; i++) begin
            s = (sent < 256 && m_q.size() < 2);
            if (s) sent++;
            tick(s, 0, 1, s ? ramp_frame(sent) : '0);
        end
        check("wrap_sent", sent, 256);
        check("wrap_cnt", oFRAME_CNT, 0);
        check("wrap_busy", oBUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_img_streamer

// File: doc/img_streamer.md
IMG_STREAMER -- requirements
Module: img_streamer

Interface
REQ-001 Parameter NPIX, default 784, pixels per frame (28x28).
REQ-002 Parameter PIX_W, default 16, normalized pixel width.
REQ-003 iCLK  input  1  single clock, all logic rising-edge.
REQ-004 iRST  input  1  reset; asynchronous, active-high.
REQ-005 iSTART  input  1  one-cycle pulse: iIMG holds a complete normalized frame (crop/normalize ImgDone).
REQ-006 iIMG  input  NPIX x PIX_W  packed frame; element 0 = top-left, row-major; sampled only on iSTART.
REQ-007 iABORT  input  1  synchronous flush (frame buffer reset).
REQ-008 oVALID  output  1  oDATA/oADDR valid to NN input stage.
REQ-009 iREADY  input  1  consumer accepts the word when oVALID&iREADY.
REQ-010 oDATA  output  PIX_W  current pixel.
REQ-011 oADDR  output  10  index of current pixel, 0..NPIX-1.
REQ-012 oLAST  output  1  high with oVALID when oADDR==NPIX-1.
REQ-013 oBUSY  output  1  streaming or pending frame held.
REQ-014 oOVF  output  1  sticky: a frame was dropped.
REQ-015 oFRAME_CNT  output  8  frames fully streamed, wraps 255->0.

Function
REQ-016 Two frame banks: ACTIVE (being streamed) and PENDING (waiting); PENDING has a full flag.
REQ-017 FSM states IDLE, STREAM; IDLE->STREAM on iSTART; STREAM->IDLE on final handshake with no pending frame and no iSTART.
REQ-018 iSTART in IDLE: iIMG captured into ACTIVE; next cycle oVALID=1, oADDR=0, oDATA=iIMG[0] (1-cycle latency).
REQ-019 All outputs registered; oDATA/oADDR/oLAST held stable while oVALID&!iREADY.
REQ-020 Each handshake advances oADDR by 1 and oDATA to next word next cycle; no bubble between words while iREADY stays high.
REQ-021 Final handshake (oADDR==NPIX-1): oFRAME_CNT increments by 1 modulo 256 next cycle.
REQ-022 Final handshake with PENDING full: PENDING moves to ACTIVE, flag clears, next cycle oADDR=0 with oVALID=1 (no gap).
REQ-023 Final handshake coinciding with iSTART and PENDING empty: iIMG goes directly to ACTIVE, streaming restarts at oADDR=0 next cycle.
REQ-024 Final handshake coinciding with iSTART and PENDING full: PENDING becomes ACTIVE, iIMG captured into PENDING.
REQ-025 iSTART in STREAM (not final handshake) with PENDING empty: iIMG captured into PENDING, flag set.
REQ-026 iSTART in STREAM with PENDING full (not final handshake): iIMG dropped, oOVF set, held until iRST.
REQ-027 oBUSY = (state==STREAM) | PENDING full, registered.
REQ-028 iABORT: next cycle state IDLE, oVALID=0, oADDR=0, oLAST=0, PENDING flag cleared; oFRAME_CNT and oOVF unchanged; iABORT dominates iSTART in the same cycle.
REQ-029 oADDR never exceeds NPIX-1; counter width fixed at 10 bits.

Reset
REQ-030 iRST asserted: state IDLE, oVALID=0, oDATA=0, oADDR=0, oLAST=0, oBUSY=0, oOVF=0, oFRAME_CNT=0, PENDING flag=0, both banks 0; effective immediately, mid-stream included.
REQ-031 First iSTART accepted is the first one sampled on a rising edge after iRST deasserts.

Structure
REQ-032 Package img_stream_pkg holds NPIX, PIX_W, ADDR_W=10, and the state enum {IDLE, STREAM}.
REQ-033 Sub-module img_bank: one NPIX x PIX_W capture register with load enable, clear, and addr-indexed read mux; instantiated twice (ACTIVE, PENDING) with bank swap implemented as a copy.

Verification
REQ-034 iSTART with iIMG[k]=k, iREADY=1: oVALID rises 1 cycle later, 784 consecutive words 0..783, oLAST only at 783, oFRAME_CNT=1, oBUSY=0 after.
REQ-035 iREADY toggling 1/0 every cycle: each word held while iREADY=0, sequence intact, frame takes 1568 cycles.
REQ-036 Frame A streaming, iSTART B at oADDR=100, iSTART C at oADDR=200: B follows A with no gap, C dropped, oOVF=1, oFRAME_CNT=2.
REQ-037 iSTART coinciding with final handshake, PENDING empty: next cycle oADDR=0 with new frame data, oFRAME_CNT +1.
REQ-038 iABORT at oADDR=300 with PENDING full: next cycle oVALID=0, oBUSY=0; oFRAME_CNT unchanged; next iSTART streams from 0.
REQ-039 iRST asserted at oADDR=500: all outputs 0 asynchronously; 256 full frames afterward wrap oFRAME_CNT to 0.
